ft2_rx_word_packer: RTL and testbench

Upstream receive stage for the serial output path. It drives the FT2 (FT245-style asynchronous FIFO) read handshake, pulls four bytes per word, packs them MSB-first into a 32-bit word, and presents that word with a one-cycle `d_ready` pulse. The consumer is the PISO serializer, which edge-detects `d_ready` and shifts `d_out` out MSB-first. A programmable inter-word gap guarantees the serializer has finished one word before the next is presented.

---
 rtl/ft2_rx_word_packer.sv | 163 ++++++++++++++++
 tb/tb_ft2_rx_word_packer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft2_rx_word_packer.sv
// FT2 (FT245-style) receive stage: reads four bytes through the RD#/RXF# handshake,
// packs them MSB-first into a 32-bit word and presents it with a one-cycle d_ready pulse.
module ft2_rx_word_packer #(
   parameter int RD_LOW_CYCLES   = 2,
   parameter int RD_HIGH_CYCLES  = 3,
   parameter int WORD_GAP_CYCLES = 40
) (
   input  logic        clk_32,
   input  logic        rst_n,
   input  logic        rxf_n_in,
   input  logic [7:0]  d_in,
   output logic        rd_n_out,
   output logic        wr_n_out,
   output logic [31:0] d_out,
   output logic        d_ready,
   output logic [7:0]  words_rx
);

   typedef enum logic [2:0] {
      IDLE,
      RD_LOW,
      RD_HIGH,
      PRESENT,
      GAP
   } state_t;

   localparam int PHASE_W = 16;
   localparam logic [PHASE_W-1:0] LOW_LAST  = PHASE_W'(RD_LOW_CYCLES - 1);
   localparam logic [PHASE_W-1:0] HIGH_LAST = PHASE_W'(RD_HIGH_CYCLES - 1);
   localparam logic [PHASE_W-1:0] GAP_LAST  =
      PHASE_W'((WORD_GAP_CYCLES > 0) ? (WORD_GAP_CYCLES - 1) : 0);
   localparam logic HAS_GAP = (WORD_GAP_CYCLES > 0);
   localparam logic [2:0] BYTES_PER_WORD = 3'd4;

   state_t r_state;
   state_t w_stateNext;

   logic               r_rxfMeta;
   logic               r_rxfSync;
   logic [PHASE_W-1:0] r_phase;
   logic [2:0]         r_byteCnt;
   logic [31:0]        r_shreg;
   logic               r_rdN;
   logic [31:0]        r_dOut;
   logic               r_dReady;
   logic [7:0]         r_wordsRx;

   logic               w_phaseDone;
   logic               w_capture;
   logic               w_present;
   logic [PHASE_W-1:0] w_phaseNext;
   logic [2:0]         w_byteCntNext;
   logic [31:0]        w_shregNext;
   logic               w_rdNNext;
   logic [31:0]        w_dOutNext;
   logic               w_dReadyNext;
   logic [7:0]         w_wordsRxNext;

   always_ff @(posedge clk_32) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Timed states end when the shared phase counter hits their last cycle.
   always_comb begin
      w_phaseDone = 1'b0;
      case (r_state)
         RD_LOW:  w_phaseDone = (r_phase == LOW_LAST);
         RD_HIGH: w_phaseDone = (r_phase == HIGH_LAST);
         GAP:     w_phaseDone = (r_phase == GAP_LAST);
         default: w_phaseDone = 1'b0;
      endcase
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE: begin
            if (!r_rxfSync) begin
               w_stateNext = RD_LOW;
            end
         end
         RD_LOW: begin
            if (w_phaseDone) begin
               w_stateNext = RD_HIGH;
            end
         end
         RD_HIGH: begin
            if (w_phaseDone) begin
               w_stateNext = (r_byteCnt == BYTES_PER_WORD) ? PRESENT : IDLE;
            end
         end
         PRESENT: begin
            w_stateNext = HAS_GAP ? GAP : IDLE;
         end
         GAP: begin
            if (w_phaseDone) begin
               w_stateNext = IDLE;
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // RD# is registered from the next state so it falls on the edge that enters RD_LOW.
   always_comb begin
      w_capture     = (r_state == RD_LOW) && w_phaseDone;
      w_present     = (r_state == PRESENT);
      w_rdNNext     = (w_stateNext != RD_LOW);
      w_phaseNext   = (w_stateNext != r_state) ? '0 : (r_phase + 1'b1);
      w_shregNext   = r_shreg;
      w_byteCntNext = r_byteCnt;
      w_dOutNext    = r_dOut;
      w_dReadyNext  = 1'b0;
      w_wordsRxNext = r_wordsRx;
      if (w_capture) begin
         w_shregNext   = {r_shreg[23:0], d_in};
         w_byteCntNext = r_byteCnt + 1'b1;
      end
      if (w_present) begin
         w_byteCntNext = '0;
         w_dOutNext    = r_shreg;
         w_dReadyNext  = 1'b1;
         w_wordsRxNext = r_wordsRx + 1'b1;
      end
   end

   always_ff @(posedge clk_32) begin
      if (!rst_n) begin
         r_rxfMeta <= 1'b1;
         r_rxfSync <= 1'b1;
         r_phase   <= '0;
         r_byteCnt <= '0;
         r_shreg   <= '0;
         r_rdN     <= 1'b1;
         r_dOut    <= '0;
         r_dReady  <= 1'b0;
         r_wordsRx <= '0;
      end else begin
         r_rxfMeta <= rxf_n_in;
         r_rxfSync <= r_rxfMeta;
         r_phase   <= w_phaseNext;
         r_byteCnt <= w_byteCntNext;
         r_shreg   <= w_shregNext;
         r_rdN     <= w_rdNNext;
         r_dOut    <= w_dOutNext;
         r_dReady  <= w_dReadyNext;
         r_wordsRx <= w_wordsRxNext;
      end
   end

   assign rd_n_out = r_rdN;
   assign wr_n_out = 1'b1;
   assign d_out    = r_dOut;
   assign d_ready  = r_dReady;
   assign words_rx = r_wordsRx;

endmodule

// File: tb/tb_ft2_rx_word_packer.sv
// Directed bench for ft2_rx_word_packer: an FT2 FIFO model feeds bytes through
// the RD#/RXF# handshake and each scenario task checks the packed words it produces.
`timescale 1ns/1ps
module tb_ft2_rx_word_packer;

   logic        clk_32 = 1'b0;
   logic        rst_n  = 1'b0;
   logic        rxf_n_in;
   logic [7:0]  d_in   = 8'h00;
   logic        rd_n_out;
   logic        wr_n_out;
   logic [31:0] d_out;
   logic        d_ready;
   logic [7:0]  words_rx;

   int errors = 0;
   int checks = 0;

   logic [7:0] fifoQ[$];
   int         fifoCount   = 0;
   logic       forceLow    = 1'b0;
   logic       readActive  = 1'b0;
   int         readCount   = 0;
   int         doubleReady = 0;
   logic       prevReady   = 1'b0;
   int         lowRun      = 0;
   int         pulseCount  = 0;
   int         badWidth    = 0;

   ft2_rx_word_packer dut (
      .clk_32   (clk_32),
      .rst_n    (rst_n),
      .rxf_n_in (rxf_n_in),
      .d_in     (d_in),
      .rd_n_out (rd_n_out),
      .wr_n_out (wr_n_out),
      .d_out    (d_out),
      .d_ready  (d_ready),
      .words_rx (words_rx)
   );

   always #15.625 clk_32 = ~clk_32;

   assign rxf_n_in = forceLow ? 1'b0 : (fifoCount == 0);

   // FIFO model: data becomes valid 14 ns after RD# falls, byte is consumed when RD# rises.
   always @(negedge rd_n_out) begin
      readActive = 1'b1;
      readCount++;
      d_in = 8'hFF;
      #14;
      if (fifoQ.size() > 0) d_in = fifoQ[0];
   end

   always @(posedge rd_n_out) begin
      if (readActive) begin
         readActive = 1'b0;
         if (fifoQ.size() > 0) begin
            void'(fifoQ.pop_front());
            fifoCount--;
         end
      end
   end

   // Watches d_ready for back-to-back highs and measures RD# low-pulse widths.
   always @(negedge clk_32) begin
      if (d_ready && prevReady) doubleReady++;
      prevReady = d_ready;
      if (rd_n_out == 1'b0) begin
         lowRun++;
      end else if (lowRun > 0) begin
         pulseCount++;
         if (lowRun != 2) badWidth++;
         lowRun = 0;
      end
   end

   task pushByte(input logic [7:0] b);
      fifoQ.push_back(b);
      fifoCount++;
   endtask

   task waitReady(output bit ok, output int n, input int limit);
      ok = 1'b0;
      n  = 0;
      for (int i = 0; i < limit && !ok; i++) begin
         @(negedge clk_32);
         n++;
         ok = d_ready;
      end
   endtask

   task test_reset;
      forceLow = 1'b1;
      rst_n    = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_32);
         checks++;
         if (rd_n_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_rd_n cycle %0d: got %b expected 1", i, rd_n_out);
         end
      end
      checks++;
      if (wr_n_out !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_wr_n: got %b expected 1", wr_n_out);
      end
      checks++;
      if (d_out !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_d_out: got %h expected 00000000", d_out);
      end
      checks++;
      if (d_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_d_ready: got %b expected 0", d_ready);
      end
      checks++;
      if (words_rx !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset_words_rx: got %0d expected 0", words_rx);
      end
      forceLow = 1'b0;
      @(negedge clk_32);
      rst_n = 1'b1;
      repeat (5) @(negedge clk_32);
   endtask

   task test_single_word;
      bit ok;
      int n;
      int extraReady;
      readCount  = 0;
      pulseCount = 0;
      badWidth   = 0;
      pushByte(8'hDE);
      pushByte(8'hAD);
      pushByte(8'hBE);
      pushByte(8'hEF);
      waitReady(ok, n, 300);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL single_ready_timeout: got no d_ready expected a pulse within 300 clocks");
      end
      checks++;
      if (d_out !== 32'hDEADBEEF) begin
         errors++;
         $display("[TB] FAIL single_d_out: got %h expected deadbeef", d_out);
      end
      checks++;
      if (words_rx !== 8'd1) begin
         errors++;
         $display("[TB] FAIL single_words_rx: got %0d expected 1", words_rx);
      end
      extraReady = 0;
      repeat (100) begin
         @(negedge clk_32);
         if (d_ready) extraReady++;
      end
      checks++;
      if (extraReady != 0) begin
         errors++;
         $display("[TB] FAIL single_extra_ready: got %0d further pulses expected 0", extraReady);
      end
      checks++;
      if (readCount != 4) begin
         errors++;
         $display("[TB] FAIL single_read_count: got %0d expected 4", readCount);
      end
      checks++;
      if (pulseCount != 4 || badWidth != 0) begin
         errors++;
         $display("[TB] FAIL single_rd_pulses: got %0d pulses, %0d not 2 clocks wide expected 4 pulses, 0 bad",
                  pulseCount, badWidth);
      end
   endtask

   task test_mid_word_stall;
      bit ok;
      int n;
      int stallBad;
      readCount = 0;
      pushByte(8'h11);
      pushByte(8'h22);
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk_32);
         ok = (readCount == 2) && (rd_n_out == 1'b1) && (fifoCount == 0);
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL stall_two_bytes: got %0d reads expected 2 within 100 clocks", readCount);
      end
      stallBad = 0;
      repeat (100) begin
         @(negedge clk_32);
         if (rd_n_out !== 1'b1 || d_ready !== 1'b0) stallBad++;
      end
      checks++;
      if (stallBad != 0) begin
         errors++;
         $display("[TB] FAIL stall_idle: got %0d active cycles expected 0", stallBad);
      end
      checks++;
      if (d_out !== 32'hDEADBEEF) begin
         errors++;
         $display("[TB] FAIL stall_d_out_held: got %h expected deadbeef", d_out);
      end
      pushByte(8'h33);
      pushByte(8'h44);
      waitReady(ok, n, 100);
      checks++;
      if (!ok || d_out !== 32'h11223344) begin
         errors++;
         $display("[TB] FAIL stall_resume_d_out: got %h (ready %b) expected 11223344", d_out, ok);
      end
      checks++;
      if (words_rx !== 8'd2) begin
         errors++;
         $display("[TB] FAIL stall_words_rx: got %0d expected 2", words_rx);
      end
   endtask

   task test_back_to_back;
      bit          ok;
      int          n;
      int          gapBad;
      logic [31:0] firstWord;
      for (int b = 1; b <= 8; b++) pushByte(8'(b));
      waitReady(ok, n, 200);
      firstWord = d_out;
      checks++;
      if (!ok || firstWord !== 32'h01020304) begin
         errors++;
         $display("[TB] FAIL b2b_first_word: got %h (ready %b) expected 01020304", firstWord, ok);
      end
      gapBad = 0;
      for (int i = 0; i < 40; i++) begin
         if (rd_n_out !== 1'b1) gapBad++;
         @(negedge clk_32);
      end
      checks++;
      if (gapBad != 0) begin
         errors++;
         $display("[TB] FAIL b2b_gap_rd_n: got %0d low cycles expected 0", gapBad);
      end
      waitReady(ok, n, 200);
      checks++;
      if (!ok || d_out !== 32'h05060708) begin
         errors++;
         $display("[TB] FAIL b2b_second_word: got %h (ready %b) expected 05060708", d_out, ok);
      end
      checks++;
      if (40 + n != 65) begin
         errors++;
         $display("[TB] FAIL b2b_period: got %0d clocks expected 65", 40 + n);
      end
      checks++;
      if (words_rx !== 8'd4) begin
         errors++;
         $display("[TB] FAIL b2b_words_rx: got %0d expected 4", words_rx);
      end
   endtask

   task test_reset_mid_word;
      bit ok;
      int n;
      readCount = 0;
      pushByte(8'h55);
      pushByte(8'h66);
      pushByte(8'h77);
      pushByte(8'h88);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk_32);
         ok = (readCount == 4);
      end
      checks++;
      if (!ok || rd_n_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrst_fourth_read: got reads=%0d rd_n=%b expected 4 reads with rd_n low",
                  readCount, rd_n_out);
      end
      rst_n = 1'b0;
      @(negedge clk_32);
      checks++;
      if (rd_n_out !== 1'b1 || d_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrst_rd_n: got rd_n=%b d_ready=%b expected 1 and 0", rd_n_out, d_ready);
      end
      checks++;
      if (d_out !== 32'h0 || words_rx !== 8'd0) begin
         errors++;
         $display("[TB] FAIL midrst_outputs: got d_out=%h words_rx=%0d expected 00000000 and 0",
                  d_out, words_rx);
      end
      rst_n = 1'b1;
      repeat (20) @(negedge clk_32);
      pushByte(8'hA1);
      pushByte(8'hA2);
      pushByte(8'hA3);
      pushByte(8'hA4);
      waitReady(ok, n, 200);
      checks++;
      if (!ok || d_out !== 32'hA1A2A3A4) begin
         errors++;
         $display("[TB] FAIL midrst_new_word: got %h (ready %b) expected a1a2a3a4", d_out, ok);
      end
      checks++;
      if (words_rx !== 8'd1) begin
         errors++;
         $display("[TB] FAIL midrst_words_rx: got %0d expected 1", words_rx);
      end
   endtask

   task test_counter_wrap;
      bit ok;
      int n;
      int seen;
      rst_n = 1'b0;
      repeat (2) @(negedge clk_32);
      rst_n = 1'b1;
      for (int j = 0; j < 1028; j++) pushByte(8'(j));
      seen = 0;
      ok   = 1'b1;
      for (int w = 1; w <= 257 && ok; w++) begin
         waitReady(ok, n, 200);
         if (ok) begin
            seen++;
            if (w == 255) begin
               checks++;
               if (words_rx !== 8'd255) begin
                  errors++;
                  $display("[TB] FAIL wrap_255: got %0d expected 255", words_rx);
               end
            end
            if (w == 256) begin
               checks++;
               if (words_rx !== 8'd0 || d_out !== 32'hFCFDFEFF) begin
                  errors++;
                  $display("[TB] FAIL wrap_256: got words_rx=%0d d_out=%h expected 0 and fcfdfeff",
                           words_rx, d_out);
               end
            end
            if (w == 257) begin
               checks++;
               if (words_rx !== 8'd1 || d_out !== 32'h00010203) begin
                  errors++;
                  $display("[TB] FAIL wrap_257: got words_rx=%0d d_out=%h expected 1 and 00010203",
                           words_rx, d_out);
               end
            end
         end
      end
      checks++;
      if (seen != 257) begin
         errors++;
         $display("[TB] FAIL wrap_word_count: got %0d words expected 257", seen);
      end
   endtask

   initial begin
      $display("[TB] starting ft2_rx_word_packer tests");
      test_reset();
      test_single_word();
      test_mid_word_stall();
      test_back_to_back();
      test_reset_mid_word();
      test_counter_wrap();
      checks++;
      if (doubleReady != 0) begin
         errors++;
         $display("[TB] FAIL ready_single_cycle: got %0d double-high cycles expected 0", doubleReady);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
